// File: rtl/stack_mem_arbiter.sv
// Arbiter sharing the single-port stack-processor memory between instruction fetch (F) and data (D).
// Define STACK_ARB_RR_EN for round-robin arbitration; otherwise D has fixed priority over F.
module stack_mem_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int MEM_LAT = 2
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_ack,
  output logic [DATA_W-1:0] f_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              owner
);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_CAPTURE, S_RESP} state_t;

  localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

  state_t     r_state;
  logic [3:0] r_cnt;
  logic       r_isWrite;
  logic       w_anyReq;
  logic       w_grantD;

  assign w_anyReq = f_req | d_req;

`ifdef STACK_ARB_RR_EN
  logic r_lastWinner;

  // With both ports requesting, the port that lost the previous grant goes first.
  assign w_grantD = d_req & (~f_req | ~r_lastWinner);

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_lastWinner <= 1'b0;
    end else if (r_state == S_IDLE && w_anyReq) begin
      r_lastWinner <= w_grantD;
    end
  end
`else
  assign w_grantD = d_req;
`endif

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_isWrite <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      f_ack     <= 1'b0;
      d_ack     <= 1'b0;
      f_rdata   <= '0;
      d_rdata   <= '0;
      busy      <= 1'b0;
      owner     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_anyReq) begin
            mem_en    <= 1'b1;
            mem_we    <= w_grantD & d_we;
            r_isWrite <= w_grantD & d_we;
            mem_addr  <= w_grantD ? d_addr : f_addr;
            if (w_grantD) begin
              mem_wdata <= d_wdata;
            end
            owner     <= w_grantD;
            busy      <= 1'b1;
            r_cnt     <= CNT_INIT;
            r_state   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          mem_en  <= 1'b0;
          mem_we  <= 1'b0;
          r_state <= (MEM_LAT == 1) ? S_CAPTURE : S_WAIT;
        end
        S_WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt <= 4'd1) begin
            r_state <= S_CAPTURE;
          end
        end
        // Read data is valid exactly in this cycle; writes keep the old rdata.
        S_CAPTURE: begin
          if (owner) begin
            d_ack <= 1'b1;
            if (!r_isWrite) begin
              d_rdata <= mem_rdata;
            end
          end else begin
            f_ack   <= 1'b1;
            f_rdata <= mem_rdata;
          end
          r_state <= S_RESP;
        end
        S_RESP: begin
          f_ack   <= 1'b0;
          d_ack   <= 1'b0;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stack_mem_arbiter.sv
// Self-checking bench for stack_mem_arbiter: one instance at MEM_LAT=2 with a memory model,
// one at MEM_LAT=1 for the short-latency corner.
module tb_stack_mem_arbiter;

  localparam int LAT = 2;
  localparam logic [15:0] L1_ADDR = 16'h0020;
  localparam logic [15:0] L1_DATA = 16'h1234;

  logic        CLK;
  logic        reset;
  logic        fReq, fAck, dReq, dWe, dAck, memEn, memWe, busy, owner;
  logic [15:0] fAddr, fRdata, dAddr, dWdata, dRdata, memAddr, memWdata, memRdata;

  logic        l1FReq, l1FAck, l1DAck, l1MemEn, l1MemWe, l1Busy, l1Owner;
  logic [15:0] l1FAddr, l1FRdata, l1DRdata, l1MemAddr, l1MemWdata, l1MemRdata;

  logic        memInit, memLoadEn;
  logic [8:0]  memLoadAddr;
  logic [15:0] memLoadData;
  logic [15:0] memArr [0:511];
  logic [15:0] rdPipe [0:LAT-1];
  logic [15:0] l1Pipe;
  logic [15:0] shadow [0:511];

  int checkCount = 0;
  int passCount  = 0;
  int bothAck = 0;
  int enTotal = 0;
  int ackTotal = 0;

  stack_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(LAT)) dut (
    .CLK(CLK), .reset(reset),
    .f_req(fReq), .f_addr(fAddr), .f_ack(fAck), .f_rdata(fRdata),
    .d_req(dReq), .d_we(dWe), .d_addr(dAddr), .d_wdata(dWdata), .d_ack(dAck), .d_rdata(dRdata),
    .mem_en(memEn), .mem_we(memWe), .mem_addr(memAddr), .mem_wdata(memWdata), .mem_rdata(memRdata),
    .busy(busy), .owner(owner)
  );

  stack_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(1)) dut1 (
    .CLK(CLK), .reset(reset),
    .f_req(l1FReq), .f_addr(l1FAddr), .f_ack(l1FAck), .f_rdata(l1FRdata),
    .d_req(1'b0), .d_we(1'b0), .d_addr(16'h0000), .d_wdata(16'h0000), .d_ack(l1DAck), .d_rdata(l1DRdata),
    .mem_en(l1MemEn), .mem_we(l1MemWe), .mem_addr(l1MemAddr), .mem_wdata(l1MemWdata), .mem_rdata(l1MemRdata),
    .busy(l1Busy), .owner(l1Owner)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [15:0] initWord(input int a);
    return 16'(a * 40503 + 23130);
  endfunction

  // Memory model: read data appears LAT cycles after the strobe cycle, garbage otherwise.
  always @(posedge CLK) begin
    if (memInit) begin
      for (int i = 0; i < 512; i++) memArr[i] <= initWord(i);
    end else if (memLoadEn) begin
      memArr[memLoadAddr] <= memLoadData;
    end else if (memEn && memWe) begin
      memArr[memAddr[8:0]] <= memWdata;
    end
    rdPipe[0] <= (memEn && !memWe) ? memArr[memAddr[8:0]] : 16'($urandom);
    for (int i = 1; i < LAT; i++) rdPipe[i] <= rdPipe[i-1];
    l1Pipe <= (l1MemEn && !l1MemWe && l1MemAddr == L1_ADDR) ? L1_DATA : 16'($urandom);
  end
  assign memRdata   = rdPipe[LAT-1];
  assign l1MemRdata = l1Pipe;

  always @(negedge CLK) begin
    if (fAck && dAck) bothAck++;
    if (memEn) enTotal++;
    if (fAck || dAck) ackTotal++;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic preload(input logic [8:0] a, input logic [15:0] v);
    memLoadEn = 1'b1; memLoadAddr = a; memLoadData = v;
    @(posedge CLK); #1;
    memLoadEn = 1'b0;
    shadow[a] = v;
  endtask

  task automatic pulseReset();
    reset = 1'b1;
    @(posedge CLK); #1;
    reset = 1'b0;
  endtask

  // Runs edges until the chosen port acks (dropping its request) plus one edge back to idle.
  task automatic observe(input int maxEdges, input bit isD, output int enCount, output int firstEn,
                         output logic [15:0] enAddr, output logic enWe, output logic [15:0] enWdata,
                         output int busyCnt, output int ackEdge);
    enCount = 0; firstEn = 0; enAddr = '0; enWe = 1'b0; enWdata = '0; busyCnt = 0; ackEdge = 0;
    for (int e = 1; e <= maxEdges; e++) begin
      @(posedge CLK); #1;
      if (memEn) begin
        enCount++;
        if (firstEn == 0) begin
          firstEn = e; enAddr = memAddr; enWe = memWe; enWdata = memWdata;
        end
      end
      if (busy) busyCnt++;
      if (ackEdge != 0) break;
      if (isD ? dAck : fAck) begin
        ackEdge = e;
        if (isD) dReq = 1'b0; else fReq = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    checkCount++;
    if ({fAck, dAck, memEn, memWe, busy, owner, memAddr, memWdata, fRdata, dRdata} !== '0) begin
      $display("[TB] FAIL reset_outputs: got %h expected 0",
               {fAck, dAck, memEn, memWe, busy, owner, memAddr, memWdata, fRdata, dRdata});
    end else passCount++;
    checkCount++;
    if ({l1FAck, l1DAck, l1MemEn, l1MemWe, l1Busy, l1Owner, l1MemAddr, l1MemWdata, l1FRdata, l1DRdata} !== '0) begin
      $display("[TB] FAIL reset_outputs_lat1: got %h expected 0",
               {l1FAck, l1DAck, l1MemEn, l1MemWe, l1Busy, l1Owner, l1MemAddr, l1MemWdata, l1FRdata, l1DRdata});
    end else passCount++;
    reset = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    checkCount++;
    if ({memEn, busy} !== 2'b00) begin
      $display("[TB] FAIL idle_no_req: got %b expected 00", {memEn, busy});
    end else passCount++;
  endtask

  task automatic test_reset_mid_wait();
    int enCount, firstEn, busyCnt, ackEdge;
    logic [15:0] enAddr, enWdata;
    logic enWe;
    dReq = 1'b1; dWe = 1'b0; dAddr = 16'h0105;
    @(posedge CLK); #1;
    checkCount++;
    if ({memEn, memAddr} !== {1'b1, 16'h0105}) begin
      $display("[TB] FAIL midwait_issue: got %h expected %h", {memEn, memAddr}, {1'b1, 16'h0105});
    end else passCount++;
    @(posedge CLK); #1;
    reset = 1'b1;
    #1;
    checkCount++;
    if ({fAck, dAck, memEn, memWe, busy, owner, memAddr, memWdata, fRdata, dRdata} !== '0) begin
      $display("[TB] FAIL midwait_async_reset: got %h expected 0",
               {fAck, dAck, memEn, memWe, busy, owner, memAddr, memWdata, fRdata, dRdata});
    end else passCount++;
    for (int k = 0; k < 2; k++) begin
      @(posedge CLK); #1;
      checkCount++;
      if ({dAck, busy} !== 2'b00) begin
        $display("[TB] FAIL midwait_held_reset: got %b expected 00", {dAck, busy});
      end else passCount++;
    end
    reset = 1'b0;
    observe(12, 1'b1, enCount, firstEn, enAddr, enWe, enWdata, busyCnt, ackEdge);
    checkCount++;
    if (firstEn !== 1 || enAddr !== 16'h0105) begin
      $display("[TB] FAIL midwait_reissue: got edge %0d addr %h expected edge 1 addr 0105", firstEn, enAddr);
    end else passCount++;
    checkCount++;
    if (ackEdge !== LAT + 2) begin
      $display("[TB] FAIL midwait_ack_edge: got %0d expected %0d", ackEdge, LAT + 2);
    end else passCount++;
    checkCount++;
    if (dRdata !== shadow[9'h105]) begin
      $display("[TB] FAIL midwait_rdata: got %h expected %h", dRdata, shadow[9'h105]);
    end else passCount++;
  endtask

  task automatic test_single_fetch();
    int enCount, firstEn, busyCnt, ackEdge;
    logic [15:0] enAddr, enWdata;
    logic enWe;
    preload(9'h010, 16'h7005);
    fReq = 1'b1; fAddr = 16'h0010;
    observe(12, 1'b0, enCount, firstEn, enAddr, enWe, enWdata, busyCnt, ackEdge);
    checkCount++;
    if (enCount !== 1) begin
      $display("[TB] FAIL fetch_en_count: got %0d expected 1", enCount);
    end else passCount++;
    checkCount++;
    if ({enAddr, enWe} !== {16'h0010, 1'b0}) begin
      $display("[TB] FAIL fetch_mem_cmd: got %h expected %h", {enAddr, enWe}, {16'h0010, 1'b0});
    end else passCount++;
    checkCount++;
    if (ackEdge !== LAT + 2) begin
      $display("[TB] FAIL fetch_ack_edge: got %0d expected %0d", ackEdge, LAT + 2);
    end else passCount++;
    checkCount++;
    if (fRdata !== 16'h7005) begin
      $display("[TB] FAIL fetch_rdata: got %h expected 7005", fRdata);
    end else passCount++;
    checkCount++;
    if (busyCnt !== LAT + 2) begin
      $display("[TB] FAIL fetch_busy_cycles: got %0d expected %0d", busyCnt, LAT + 2);
    end else passCount++;
    checkCount++;
    if (owner !== 1'b0) begin
      $display("[TB] FAIL fetch_owner: got %b expected 0", owner);
    end else passCount++;
    repeat (2) @(posedge CLK);
    #1;
    checkCount++;
    if ({fRdata, fAck, memEn} !== {16'h7005, 2'b00}) begin
      $display("[TB] FAIL fetch_rdata_held: got %h expected %h", {fRdata, fAck, memEn}, {16'h7005, 2'b00});
    end else passCount++;
  endtask

  task automatic test_data_write();
    int enCount, firstEn, busyCnt, ackEdge;
    logic [15:0] enAddr, enWdata, prevD;
    logic enWe;
    prevD = dRdata;
    dReq = 1'b1; dWe = 1'b1; dAddr = 16'h0100; dWdata = 16'hBEEF;
    observe(12, 1'b1, enCount, firstEn, enAddr, enWe, enWdata, busyCnt, ackEdge);
    checkCount++;
    if (enCount !== 1) begin
      $display("[TB] FAIL write_en_count: got %0d expected 1", enCount);
    end else passCount++;
    checkCount++;
    if ({enAddr, enWe, enWdata} !== {16'h0100, 1'b1, 16'hBEEF}) begin
      $display("[TB] FAIL write_mem_cmd: got %h expected %h", {enAddr, enWe, enWdata}, {16'h0100, 1'b1, 16'hBEEF});
    end else passCount++;
    checkCount++;
    if (ackEdge !== LAT + 2) begin
      $display("[TB] FAIL write_ack_edge: got %0d expected %0d", ackEdge, LAT + 2);
    end else passCount++;
    checkCount++;
    if (dRdata !== prevD) begin
      $display("[TB] FAIL write_rdata_unchanged: got %h expected %h", dRdata, prevD);
    end else passCount++;
    checkCount++;
    if ({owner, memEn, memWe} !== 3'b100) begin
      $display("[TB] FAIL write_owner_idle: got %b expected 100", {owner, memEn, memWe});
    end else passCount++;
    shadow[9'h100] = 16'hBEEF;
    dReq = 1'b1; dWe = 1'b0;
    observe(12, 1'b1, enCount, firstEn, enAddr, enWe, enWdata, busyCnt, ackEdge);
    checkCount++;
    if (dRdata !== shadow[9'h100]) begin
      $display("[TB] FAIL write_readback: got %h expected %h", dRdata, shadow[9'h100]);
    end else passCount++;
  endtask

  task automatic test_arbitration();
    int fLeft, dLeft, lastW, winner;
    int expOrder[$];
    int obsOrder[$];
    pulseReset();
    // Model: both requesters stay pending until their quota is served.
    fLeft = 2; dLeft = 2; lastW = 0;
    while (fLeft > 0 || dLeft > 0) begin
      if (fLeft > 0 && dLeft > 0) begin
`ifdef STACK_ARB_RR_EN
        winner = (lastW == 0) ? 1 : 0;
`else
        winner = 1;
`endif
      end else winner = (dLeft > 0) ? 1 : 0;
      expOrder.push_back(winner);
      if (winner == 1) dLeft--; else fLeft--;
      lastW = winner;
    end
    fLeft = 2; dLeft = 2;
    fReq = 1'b1; fAddr = 16'h0030;
    dReq = 1'b1; dWe = 1'b0; dAddr = 16'h0130;
    for (int e = 0; e < 100 && (fLeft > 0 || dLeft > 0); e++) begin
      @(posedge CLK); #1;
      if (fAck) begin
        obsOrder.push_back(0);
        checkCount++;
        if (fRdata !== shadow[fAddr[8:0]]) begin
          $display("[TB] FAIL arb_f_rdata: got %h expected %h", fRdata, shadow[fAddr[8:0]]);
        end else passCount++;
        fLeft--;
        if (fLeft == 0) fReq = 1'b0; else fAddr = fAddr + 16'd1;
      end
      if (dAck) begin
        obsOrder.push_back(1);
        checkCount++;
        if (dRdata !== shadow[dAddr[8:0]]) begin
          $display("[TB] FAIL arb_d_rdata: got %h expected %h", dRdata, shadow[dAddr[8:0]]);
        end else passCount++;
        dLeft--;
        if (dLeft == 0) dReq = 1'b0; else dAddr = dAddr + 16'd1;
      end
    end
    fReq = 1'b0; dReq = 1'b0;
    @(posedge CLK); #1;
    checkCount++;
    if (obsOrder.size() !== expOrder.size()) begin
      $display("[TB] FAIL arb_count: got %0d expected %0d", obsOrder.size(), expOrder.size());
    end else passCount++;
    for (int i = 0; i < expOrder.size() && i < obsOrder.size(); i++) begin
      checkCount++;
      if (obsOrder[i] !== expOrder[i]) begin
        $display("[TB] FAIL arb_order[%0d]: got port %0d expected port %0d (0=F,1=D)", i, obsOrder[i], expOrder[i]);
      end else passCount++;
    end
  endtask

  task automatic test_back_to_back();
    int enEdges[$];
    logic [15:0] enAddrs[$];
    int acks = 0;
    dReq = 1'b1; dWe = 1'b0; dAddr = 16'h0140;
    for (int e = 1; e <= 40; e++) begin
      @(posedge CLK); #1;
      if (memEn) begin
        enEdges.push_back(e);
        enAddrs.push_back(memAddr);
      end
      if (acks == 2) break;
      if (dAck) begin
        acks++;
        checkCount++;
        if (dRdata !== shadow[dAddr[8:0]]) begin
          $display("[TB] FAIL b2b_rdata%0d: got %h expected %h", acks, dRdata, shadow[dAddr[8:0]]);
        end else passCount++;
        if (acks == 1) dAddr = 16'h0141; else dReq = 1'b0;
      end
    end
    checkCount++;
    if (enEdges.size() !== 2) begin
      $display("[TB] FAIL b2b_en_count: got %0d expected 2", enEdges.size());
    end else passCount++;
    if (enEdges.size() == 2) begin
      checkCount++;
      if (enEdges[1] - enEdges[0] !== LAT + 3) begin
        $display("[TB] FAIL b2b_spacing: got %0d expected %0d", enEdges[1] - enEdges[0], LAT + 3);
      end else passCount++;
      checkCount++;
      if (enAddrs[1] !== 16'h0141) begin
        $display("[TB] FAIL b2b_second_addr: got %h expected 0141", enAddrs[1]);
      end else passCount++;
    end
  endtask

  task automatic test_random();
    int enStart, ackStart;
    pulseReset();
    enStart = enTotal; ackStart = ackTotal;
    fork
      begin
        for (int n = 0; n < 8; n++) begin
          bit got = 0;
          repeat ($urandom_range(0, 3)) begin @(posedge CLK); #1; end
          fAddr = 16'($urandom_range(0, 255)); fReq = 1'b1;
          for (int e = 0; e < 60; e++) begin
            @(posedge CLK); #1;
            if (fAck) begin got = 1; break; end
          end
          checkCount++;
          if (!got) $display("[TB] FAIL rand_f_timeout: got no ack expected ack within 60 edges");
          else if (fRdata !== shadow[fAddr[8:0]])
            $display("[TB] FAIL rand_f_rdata: got %h expected %h", fRdata, shadow[fAddr[8:0]]);
          else passCount++;
          fReq = 1'b0;
        end
      end
      begin
        for (int n = 0; n < 10; n++) begin
          bit got = 0;
          logic [15:0] prevD;
          repeat ($urandom_range(0, 3)) begin @(posedge CLK); #1; end
          prevD = dRdata;
          dAddr = 16'h0100 + 16'($urandom_range(0, 255));
          dWe = 1'($urandom_range(0, 1)); dWdata = 16'($urandom); dReq = 1'b1;
          for (int e = 0; e < 60; e++) begin
            @(posedge CLK); #1;
            if (dAck) begin got = 1; break; end
          end
          checkCount++;
          if (!got) $display("[TB] FAIL rand_d_timeout: got no ack expected ack within 60 edges");
          else if (dWe) begin
            shadow[dAddr[8:0]] = dWdata;
            if (dRdata !== prevD) $display("[TB] FAIL rand_d_write_rdata: got %h expected %h", dRdata, prevD);
            else passCount++;
          end else if (dRdata !== shadow[dAddr[8:0]])
            $display("[TB] FAIL rand_d_rdata: got %h expected %h", dRdata, shadow[dAddr[8:0]]);
          else passCount++;
          dReq = 1'b0;
        end
      end
    join
    repeat (2) @(posedge CLK);
    #1;
    checkCount++;
    if (enTotal - enStart !== ackTotal - ackStart) begin
      $display("[TB] FAIL rand_en_vs_ack: got %0d strobes expected %0d", enTotal - enStart, ackTotal - ackStart);
    end else passCount++;
  endtask

  task automatic test_lat1();
    int enCount = 0, busyCnt = 0, ackEdge = 0;
    l1FReq = 1'b1; l1FAddr = L1_ADDR;
    for (int e = 1; e <= 10; e++) begin
      @(posedge CLK); #1;
      if (l1MemEn) enCount++;
      if (l1Busy) busyCnt++;
      if (ackEdge != 0) break;
      if (l1FAck) begin ackEdge = e; l1FReq = 1'b0; end
    end
    checkCount++;
    if (ackEdge !== 3) begin
      $display("[TB] FAIL lat1_ack_edge: got %0d expected 3", ackEdge);
    end else passCount++;
    checkCount++;
    if (l1FRdata !== L1_DATA) begin
      $display("[TB] FAIL lat1_rdata: got %h expected %h", l1FRdata, L1_DATA);
    end else passCount++;
    checkCount++;
    if (busyCnt !== 3) begin
      $display("[TB] FAIL lat1_busy_cycles: got %0d expected 3", busyCnt);
    end else passCount++;
    checkCount++;
    if (enCount !== 1) begin
      $display("[TB] FAIL lat1_en_count: got %0d expected 1", enCount);
    end else passCount++;
  endtask

  initial begin
    reset = 1'b1;
    fReq = 1'b0; fAddr = '0; dReq = 1'b0; dWe = 1'b0; dAddr = '0; dWdata = '0;
    l1FReq = 1'b0; l1FAddr = '0;
    memInit = 1'b1; memLoadEn = 1'b0; memLoadAddr = '0; memLoadData = '0;
    for (int i = 0; i < 512; i++) shadow[i] = initWord(i);
    @(posedge CLK); #1;
    memInit = 1'b0;
    $display("[TB] starting stack_mem_arbiter bench");
    test_reset();
    test_reset_mid_wait();
    test_single_fetch();
    test_data_write();
    test_arbitration();
    test_back_to_back();
    test_random();
    test_lat1();
    checkCount++;
    if (bothAck !== 0) begin
      $display("[TB] FAIL ack_exclusive: got %0d overlapping cycles expected 0", bothAck);
    end else passCount++;
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/stack_mem_arbiter.md
Name: stack_mem_arbiter

Overview:
- Shares the single-port data/instruction memory between two requesters of the stack processor: instruction fetch (port F) and the data push/pop path (port D).
- Sequences each access: grant, one-cycle memory enable, fixed-latency wait, then response capture and an ack pulse.
- Exports a busy flag so the control decoder can hold PCWrite and stack updates while an access is in flight.

Parameters:
- ADDR_W, 16, memory address width.
- DATA_W, 16, memory word width.
- MEM_LAT, 2, cycles from the mem_en cycle to valid mem_rdata; legal range 1..15.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- f_req  in  1  fetch request; held high until f_ack.
- f_addr  in  ADDR_W  fetch address; stable while f_req is high.
- f_ack  out  1  one-cycle fetch completion pulse.
- f_rdata  out  DATA_W  fetched word; valid when f_ack=1, then held.
- d_req  in  1  data request; held high until d_ack.
- d_we  in  1  1=write (pop to memory), 0=read (push from memory).
- d_addr  in  ADDR_W  data address; stable while d_req is high.
- d_wdata  in  DATA_W  write data; stable while d_req is high.
- d_ack  out  1  one-cycle data completion pulse.
- d_rdata  out  DATA_W  read word; valid when d_ack=1, then held.
- mem_en  out  1  memory access strobe, high exactly one cycle per transaction.
- mem_we  out  1  memory write enable, qualified by mem_en.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after the mem_en cycle.
- busy  out  1  high in any non-IDLE state.
- owner  out  1  port of the current or last transaction: 0=F, 1=D.

Behaviour:
- Reset (asynchronous, immediate):
  - State goes to IDLE.
  - mem_en, mem_we, f_ack, d_ack, busy, owner go to 0.
  - mem_addr, mem_wdata, f_rdata, d_rdata go to 0.
  - Latency counter goes to 0; any in-flight transaction is dropped with no ack.
- All outputs are registered.
- States:
  - IDLE: if any request is high, latch the winner's addr/we/wdata into mem_* and set mem_en=1, owner, busy=1, cnt=MEM_LAT-1. Go to ISSUE.
  - ISSUE (mem_en=1 this cycle): next edge clears mem_en and mem_we. If MEM_LAT=1, go to CAPTURE; otherwise go to WAIT.
  - WAIT: decrement cnt each cycle. When cnt reaches 1, go to CAPTURE.
  - CAPTURE: this cycle is MEM_LAT cycles after ISSUE. Register mem_rdata into the owner's rdata (writes leave rdata unchanged), pulse the owner's ack=1, and go to RESP.
  - RESP (ack high): requests are ignored this cycle, because the requester is still dropping or changing req. Next edge: ack=0, busy=0, go to IDLE.
- Transaction length: IDLE sample to ack = MEM_LAT+2 edges. Back-to-back throughput is one transaction per MEM_LAT+3 cycles.
- Arbitration happens only in IDLE.
  - Default fixed priority: D wins over F, so a stack access in execute is never starved by prefetch.
  - The losing request stays pending and is served in the next IDLE.
- Request inputs are not sampled outside IDLE. A req that rises and falls during busy is lost; this is a protocol violation by the requester.
- f_ack and d_ack are never high in the same cycle.
- mem_addr and mem_wdata hold their last values after mem_en falls.

Optional Feature:
- STACK_ARB_RR_EN defined: round-robin arbitration.
  - A 1-bit last-winner register (reset 0 = F) gives priority to the port that did not win the previous granted transaction, only when both requests are high.
  - A single requester always wins.
- STACK_ARB_RR_EN undefined: fixed D-over-F priority; no last-winner register.

Test Plan:
- Reset mid-WAIT: assert reset during cnt=1 with d_req=1 -> all outputs 0 immediately, no d_ack; after release with d_req still high, the transaction reissues from IDLE.
- Single fetch, MEM_LAT=2, f_addr=0x0010, memory returns 0x7005 -> mem_en one cycle with addr 0x0010, we=0; f_ack on the 4th edge after sampling; f_rdata=0x7005; busy high 4 cycles.
- Data write: d_we=1, d_addr=0x0100, d_wdata=0xBEEF -> mem_en=mem_we=1 for one cycle with those values; d_ack pulses; d_rdata unchanged; memory word 0x0100 reads back 0xBEEF.
- Simultaneous f_req and d_req, held high across repeated transactions:
  - Fixed priority: order D,F.
  - STACK_ARB_RR_EN defined: order D,F,D,F... (first D, since last winner resets to F).
- Back-to-back: d_req held and re-presented with new d_addr in the cycle after d_ack -> next mem_en exactly MEM_LAT+3 cycles after the previous one; no request accepted in the RESP cycle.
- MEM_LAT=1 corner: fetch returns 0x1234 -> f_ack 3 edges after sampling; WAIT state never entered.
